// File: rtl/riscv_pkg.sv
// Shared RV32 types for the retire-trace path: datapath width, trace packet layout and filter modes.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int TRACE_SEQW = 16;

    typedef enum logic [1:0] {
        TRC_ALL = 2'd0,
        TRC_REG = 2'd1,
        TRC_MEM = 2'd2
    } trace_mode_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       instr;
        logic [4:0]            rd;
        logic [XLEN-1:0]       rd_data;
        logic [XLEN-1:0]       mem_addr;
        logic [XLEN-1:0]       mem_data;
        logic                  mem_wrt;
        logic                  mem_read;
        logic [TRACE_SEQW-1:0] seq;
    } retire_pkt_t;

    // Mode 3 is reserved and keeps everything, same as TRC_ALL.
    function automatic logic trace_keep(input logic [1:0] mode, input logic [4:0] rd,
                                        input logic mem_wrt, input logic mem_read);
        case (mode)
            TRC_REG: return rd != 5'd0;
            TRC_MEM: return mem_wrt | mem_read;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_retire_fifo.sv
// Multi-push (up to NPUSH per cycle), single-pop FIFO of retire packets.
// Latency 1: a packet written at an edge is at the head the following cycle.
// Backpressure: caller must never push more than free_o; head holds while pop_i is low.
module riscv_retire_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NPUSH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int NW   = $clog2(NPUSH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          flush_i,
    input  logic [NW-1:0]                 push_cnt_i,
    input  retire_pkt_t [NPUSH-1:0]       push_dat_i,
    input  logic                          pop_i,
    output logic                          head_vld_o,
    output retire_pkt_t                   head_dat_o,
    output logic [AW:0]                   count_o,
    output logic [AW:0]                   free_o
);

    retire_pkt_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;

    assign pop        = pop_i & (count != '0) & ~flush_i;
    assign head_vld_o = count != '0;
    assign head_dat_o = mem[rd_ptr];
    assign count_o    = count;
    // A pop in the same cycle frees its slot for an incoming push.
    assign free_o     = (AW+1)'(DEPTH) - count + {{AW{1'b0}}, pop};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt_i);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push_cnt_i) - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            for (int k = 0; k < NPUSH; k++) begin
                if (k < int'(push_cnt_i)) begin
                    mem[wr_ptr + AW'(k)] <= push_dat_i[k];
                end
            end
        end
    end

endmodule

// File: rtl/riscv_retire_tracer.sv
// Filters, sequence-tags and compacts up to NRET retire packets per cycle into a trace FIFO.
// Latency 1 from capture to out_valid_o; no combinational path from ret_* to out_*.
// Backpressure: eligible packets beyond FIFO free space are dropped and counted, never stalled.
module riscv_retire_tracer
    import riscv_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 16,
    parameter int SEQW  = TRACE_SEQW,
    parameter int CNTW  = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [1:0]                mode_i,
    input  logic [NRET-1:0]           ret_valid_i,
    input  logic [NRET*XLEN-1:0]      ret_pc_i,
    input  logic [NRET*XLEN-1:0]      ret_instr_i,
    input  logic [NRET*5-1:0]         ret_rd_i,
    input  logic [NRET*XLEN-1:0]      ret_rd_data_i,
    input  logic [NRET*XLEN-1:0]      ret_mem_addr_i,
    input  logic [NRET*XLEN-1:0]      ret_mem_data_i,
    input  logic [NRET-1:0]           ret_mem_wrt_i,
    input  logic [NRET-1:0]           ret_mem_read_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output retire_pkt_t               out_pkt_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [CNTW-1:0]           drop_cnt_o,
    output logic                      overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(NRET + 1);

    logic [NRET-1:0]          elig;
    logic [NRET-1:0]          acc;
    logic [NW-1:0]            rank [NRET];
    logic [NW-1:0]            n_elig;
    logic [NW-1:0]            n_acc;
    logic [NW-1:0]            n_drop;
    logic [AW:0]              fifo_free;
    logic [SEQW-1:0]          seq_base;
    logic [CNTW:0]            drop_sum;
    retire_pkt_t              chan_pkt [NRET];
    retire_pkt_t [NRET-1:0]   push_dat;

    // Rank = number of lower-index eligible channels; it sets both seq offset and FIFO slot.
    always_comb begin
        elig   = '0;
        acc    = '0;
        rank   = '{default: '0};
        n_elig = '0;
        n_acc  = '0;
        for (int k = 0; k < NRET; k++) begin
            elig[k] = enable_i & ret_valid_i[k]
                    & trace_keep(mode_i, ret_rd_i[k*5 +: 5], ret_mem_wrt_i[k], ret_mem_read_i[k]);
            rank[k] = n_elig;
            acc[k]  = elig[k] & ((AW+1)'(n_elig) < fifo_free);
            if (elig[k]) n_elig = n_elig + NW'(1);
            if (acc[k])  n_acc  = n_acc + NW'(1);
        end
    end

    assign n_drop = n_elig - n_acc;

    always_comb begin
        push_dat = '0;
        for (int k = 0; k < NRET; k++) begin
            chan_pkt[k].pc       = ret_pc_i[k*XLEN +: XLEN];
            chan_pkt[k].instr    = ret_instr_i[k*XLEN +: XLEN];
            chan_pkt[k].rd       = ret_rd_i[k*5 +: 5];
            chan_pkt[k].rd_data  = ret_rd_data_i[k*XLEN +: XLEN];
            chan_pkt[k].mem_addr = ret_mem_addr_i[k*XLEN +: XLEN];
            chan_pkt[k].mem_data = ret_mem_data_i[k*XLEN +: XLEN];
            chan_pkt[k].mem_wrt  = ret_mem_wrt_i[k];
            chan_pkt[k].mem_read = ret_mem_read_i[k];
            chan_pkt[k].seq      = TRACE_SEQW'(seq_base + SEQW'(rank[k]));
        end
        for (int j = 0; j < NRET; j++) begin
            for (int k = 0; k < NRET; k++) begin
                if (acc[k] && rank[k] == NW'(j)) push_dat[j] = chan_pkt[k];
            end
        end
    end

    riscv_retire_fifo #(
        .DEPTH (DEPTH),
        .NPUSH (NRET)
    ) u_fifo (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .flush_i    (clear_i),
        .push_cnt_i (n_acc),
        .push_dat_i (push_dat),
        .pop_i      (out_ready_i),
        .head_vld_o (out_valid_o),
        .head_dat_o (out_pkt_o),
        .count_o    (count_o),
        .free_o     (fifo_free)
    );

    assign drop_sum = {1'b0, drop_cnt_o} + (CNTW+1)'(n_drop);

    // Dropped packets still consume a seq value so the sink can see the gap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            seq_base   <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            seq_base   <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            seq_base <= seq_base + SEQW'(n_elig);
            if (n_drop != '0) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
            end
        end
    end

endmodule

// File: doc/riscv_retire_tracer.md
Name: riscv_retire_tracer

Overview:
- Multi-channel retire-trace capture buffer placed between one or more RV32 cores' retire ports and a debug/trace sink.
- Each cycle, accepts up to NRET retire packets (pc, instr, rd, mem), filters them by mode, and tags each with a sequence number.
- Buffers packets in a DEPTH-entry FIFO and drains them through one valid/ready port.
- Reports dropped packets and sticky overflow so the testbench or debug host can detect trace gaps.

Parameters:
- XLEN, 32, datapath width; taken from riscv_pkg.
- NRET, 2, retire channels per cycle; range 1..4.
- DEPTH, 16, FIFO entries; power of two, at least NRET.
- SEQW, 16, sequence-number width.
- CNTW, 16, drop-counter width.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- enable_i  in  1  capture enable; when 0, all inputs are ignored and seq does not advance.
- clear_i  in  1  synchronous flush of FIFO, seq, drop count and overflow flag.
- mode_i  in  2  filter: 0 all, 1 register writes only (rd!=0), 2 memory ops only (wrt|read), 3 reserved, behaves as 0.
- ret_valid_i  in  NRET  per-channel retire strobe.
- ret_pc_i  in  NRET*XLEN  retired PC per channel.
- ret_instr_i  in  NRET*XLEN  retired instruction.
- ret_rd_i  in  NRET*5  destination register.
- ret_rd_data_i  in  NRET*XLEN  register write data.
- ret_mem_addr_i  in  NRET*XLEN  memory address.
- ret_mem_data_i  in  NRET*XLEN  memory data.
- ret_mem_wrt_i  in  NRET  store flag.
- ret_mem_read_i  in  NRET  load flag.
- out_valid_o  out  1  head packet valid.
- out_ready_i  in  1  sink accepts head.
- out_pkt_o  out  $bits(retire_pkt_t)  head packet, including seq.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  CNTW  saturating count of dropped packets.
- overflow_o  out  1  sticky; set on any drop.

Behaviour:
- Reset (rstn_i low, asynchronous): pointers, count_o, seq, drop_cnt_o and overflow_o go to 0; out_valid_o goes to 0. FIFO storage is not reset.
- Eligibility: a channel is eligible when enable_i & ret_valid_i[k] & filter(mode_i) all hold. Filtered packets are neither stored nor counted as drops.
- Ordering: eligible channels are processed in ascending index order. Channel order defines program order.
- Sequence: each eligible packet receives seq = base + (number of lower-index eligible channels). base then advances by the total eligible count, mod 2^SEQW (wraps silently). Dropped packets still consume a seq value, so the sink sees gaps.
- Free space: free = DEPTH - count + pop, where pop = out_valid_o & out_ready_i in the same cycle.
- Accept/drop: the lowest-index eligible packets up to free are written. Remaining eligible packets are dropped.
- Drop accounting: drop_cnt_o += number dropped, saturating at 2^CNTW-1. overflow_o is set if any packet is dropped.
- Output: FIFO is fall-through from registered storage. A packet written at edge N gives out_valid_o=1 in the cycle after N (latency 1). No combinational path from ret_*_i to out_*.
- Head stability: out_pkt_o and out_valid_o stay stable while out_valid_o & !out_ready_i.
- Full FIFO with a pop in the same cycle: one slot is freed and may be refilled in that cycle.
- Empty FIFO: out_valid_o=0. out_ready_i has no effect.
- clear_i: highest priority. In the clear cycle, push and pop are suppressed and no drop is counted. The next cycle shows count_o=0 and seq base=0.
- Pointers: log2(DEPTH) bits with wrap. count_o is tracked separately, range 0..DEPTH.

Decomposition:
- riscv_pkg gains:
  - retire_pkt_t (pc, instr, rd, rd_data, mem_addr, mem_data, mem_wrt, mem_read, seq[SEQW]).
  - trace_mode_e (TRC_ALL, TRC_REG, TRC_MEM).
  - TRACE_SEQW default.
- Sub-module riscv_retire_fifo: generic multi-push (up to NRET), single-pop FIFO of retire_pkt_t with count and free outputs.
- The top level holds filtering, seq assignment, compaction of eligible channels and drop accounting.

Test Plan:
- Reset then NRET=2 both valid, mode 0, pc 0x0/0x4, sink ready → out shows pc 0x0 seq 0, then pc 0x4 seq 1, one cycle after capture; count_o returns to 0.
- Mode 1, ch0 rd=0, ch1 rd=5 data 0xDEAD → only ch1 stored with seq 0; drop_cnt_o=0.
- Sink held not ready, 9 cycles of 2 valid retires (DEPTH=16) → 16 stored, 2 dropped, drop_cnt_o=2, overflow_o=1; drained seqs 0..15, next accepted seq is 18.
- Full FIFO, out_ready_i=1, single retire → accepted in the same cycle, count_o stays 16, no drop.
- Assert clear_i with 5 entries and a concurrent valid retire → next cycle count_o=0, drop_cnt_o=0, overflow_o=0; next retire gets seq 0.
- rstn_i pulsed low mid-drain with 7 entries → out_valid_o drops to 0 immediately (asynchronous); all counters read 0 after release.
